// File: rtl/mem_port_arbiter.sv
// Shares one memory port between instruction fetch and the MEM-stage load/store.
// Data has fixed priority over fetch; define ARB_FAIRNESS_EN to bound data streaks while fetch waits.
module mem_port_arbiter #(
  parameter int ADDR_W        = 32,
  parameter int DATA_W        = 32,
  parameter int MAX_DM_STREAK = 4
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_if_req,
  input  logic [ADDR_W-1:0]     i_if_addr,
  input  logic                  i_flush,
  output logic                  o_if_valid,
  output logic [DATA_W-1:0]     o_if_rdata,
  output logic                  o_stall_if,
  input  logic                  i_dm_read,
  input  logic                  i_dm_write,
  input  logic [ADDR_W-1:0]     i_dm_addr,
  input  logic [DATA_W-1:0]     i_dm_wdata,
  input  logic [DATA_W/8-1:0]   i_dm_mask,
  output logic                  o_dm_valid,
  output logic [DATA_W-1:0]     o_dm_rdata,
  output logic                  o_stall_mem,
  output logic                  o_mem_req,
  output logic                  o_mem_we,
  output logic [ADDR_W-1:0]     o_mem_addr,
  output logic [DATA_W-1:0]     o_mem_wdata,
  output logic [DATA_W/8-1:0]   o_mem_mask,
  input  logic                  i_mem_ready,
  input  logic                  i_mem_rvalid,
  input  logic [DATA_W-1:0]     i_mem_rdata
);

  localparam int MASK_W = DATA_W / 8;

  if (MAX_DM_STREAK < 1 || MAX_DM_STREAK > 15) begin : g_bad_streak
    $error("MAX_DM_STREAK must be within 1..15");
  end

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    REQ_DM  = 3'd1,
    REQ_IF  = 3'd2,
    WAIT_DM = 3'd3,
    WAIT_IF = 3'd4
  } state_t;

  state_t state_q, state_d;
  logic   drop_q, drop_d;

  logic   dm_req, dm_want, if_want;
  logic   grant_dm, grant_if, fetch_turn;
  logic   mem_req_d, dm_done, if_done, if_keep;
  logic   stall_mem_raw;

  logic                req_we_p0;
  logic [ADDR_W-1:0]   req_addr_p0;
  logic [DATA_W-1:0]   req_wdata_p0;
  logic [MASK_W-1:0]   req_mask_p0;

  logic                dm_vld_p1, if_vld_p1;
  logic [DATA_W-1:0]   dm_rdata_p1, if_rdata_p1;

  // A requester whose result is being delivered this cycle still shows its old
  // request; masking with the valid pulse keeps it from being granted twice.
  assign dm_req  = i_dm_read | i_dm_write;
  assign dm_want = dm_req & ~dm_vld_p1;
  assign if_want = i_if_req & ~i_flush & ~if_vld_p1;

`ifdef ARB_FAIRNESS_EN
  localparam logic [3:0] STREAK_MAX = 4'(MAX_DM_STREAK);

  logic [3:0] streak_q;

  function automatic logic [3:0] sat_inc(input logic [3:0] s);
    return (s >= STREAK_MAX) ? STREAK_MAX : s + 4'd1;
  endfunction

  assign fetch_turn = if_want & (streak_q == STREAK_MAX);

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      streak_q <= '0;
    end else if (!i_if_req || grant_if) begin
      streak_q <= '0;
    end else if (grant_dm) begin
      streak_q <= sat_inc(streak_q);
    end
  end
`else
  assign fetch_turn = 1'b0;
`endif

  assign grant_dm = (state_q == IDLE) & dm_want & ~fetch_turn;
  assign grant_if = (state_q == IDLE) & if_want & (~dm_want | fetch_turn);

  always_comb begin
    state_d   = state_q;
    drop_d    = drop_q;
    mem_req_d = 1'b0;
    dm_done   = 1'b0;
    if_done   = 1'b0;
    case (state_q)
      IDLE: begin
        if (grant_dm) begin
          state_d = REQ_DM;
        end else if (grant_if) begin
          state_d = REQ_IF;
        end
      end
      REQ_DM: begin
        mem_req_d = 1'b1;
        if (i_mem_ready) state_d = WAIT_DM;
      end
      REQ_IF: begin
        mem_req_d = 1'b1;
        if (i_flush) drop_d = 1'b1;
        if (i_mem_ready) state_d = WAIT_IF;
      end
      WAIT_DM: begin
        if (i_mem_rvalid) begin
          dm_done = 1'b1;
          state_d = IDLE;
        end
      end
      WAIT_IF: begin
        if (i_flush) drop_d = 1'b1;
        if (i_mem_rvalid) begin
          if_done = 1'b1;
          drop_d  = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // A flushed fetch still runs to completion on the port; only its delivery is dropped.
  assign if_keep = if_done & ~drop_q & ~i_flush;

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state_q   <= IDLE;
      drop_q    <= 1'b0;
      dm_vld_p1 <= 1'b0;
      if_vld_p1 <= 1'b0;
    end else begin
      state_q   <= state_d;
      drop_q    <= drop_d;
      dm_vld_p1 <= dm_done;
      if_vld_p1 <= if_keep;
    end
  end

  // Issue stage: request fields captured at grant and held until accepted.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      req_we_p0    <= 1'b0;
      req_addr_p0  <= '0;
      req_wdata_p0 <= '0;
      req_mask_p0  <= '0;
    end else if (grant_dm) begin
      req_we_p0    <= i_dm_write;
      req_addr_p0  <= i_dm_addr;
      req_wdata_p0 <= i_dm_wdata;
      req_mask_p0  <= i_dm_write ? i_dm_mask : {MASK_W{1'b1}};
    end else if (grant_if) begin
      req_we_p0    <= 1'b0;
      req_addr_p0  <= i_if_addr;
      req_mask_p0  <= {MASK_W{1'b1}};
    end
  end

  // Response stage: result routed back to the owner of the outstanding access.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      dm_rdata_p1 <= '0;
      if_rdata_p1 <= '0;
    end else begin
      if (dm_done) dm_rdata_p1 <= i_mem_rdata;
      if (if_keep) if_rdata_p1 <= i_mem_rdata;
    end
  end

  // Stalls are combinational on the live requests, forced low while reset is held.
  assign stall_mem_raw = dm_req & ~dm_vld_p1;
  assign o_stall_mem   = i_rst & stall_mem_raw;
  assign o_stall_if    = i_rst & ((i_if_req & ~if_vld_p1) | stall_mem_raw);

  assign o_mem_req   = mem_req_d;
  assign o_mem_we    = req_we_p0;
  assign o_mem_addr  = req_addr_p0;
  assign o_mem_wdata = req_wdata_p0;
  assign o_mem_mask  = req_mask_p0;
  assign o_dm_valid  = dm_vld_p1;
  assign o_dm_rdata  = dm_rdata_p1;
  assign o_if_valid  = if_vld_p1;
  assign o_if_rdata  = if_rdata_p1;

`ifndef SYNTHESIS
  a_dm_rw_excl: assert property (@(posedge i_clk) disable iff (!i_rst)
    !(i_dm_read && i_dm_write));
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed scenarios followed by randomized traffic
// checked against a transaction-level model of the arbitration rules.
module tb_mem_port_arbiter;

`ifdef ARB_FAIRNESS_EN
  localparam int MAXS = 2;
`else
  localparam int MAXS = 4;
`endif

  logic        i_clk = 1'b0;
  logic        i_rst = 1'b0;
  logic        i_if_req = 1'b0;
  logic [31:0] i_if_addr = '0;
  logic        i_flush = 1'b0;
  logic        o_if_valid;
  logic [31:0] o_if_rdata;
  logic        o_stall_if;
  logic        i_dm_read = 1'b0;
  logic        i_dm_write = 1'b0;
  logic [31:0] i_dm_addr = '0;
  logic [31:0] i_dm_wdata = '0;
  logic [3:0]  i_dm_mask = '0;
  logic        o_dm_valid;
  logic [31:0] o_dm_rdata;
  logic        o_stall_mem;
  logic        o_mem_req;
  logic        o_mem_we;
  logic [31:0] o_mem_addr;
  logic [31:0] o_mem_wdata;
  logic [3:0]  o_mem_mask;
  logic        i_mem_ready = 1'b0;
  logic        i_mem_rvalid = 1'b0;
  logic [31:0] i_mem_rdata = '0;

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MAX_DM_STREAK(MAXS)) dut (
    .i_clk(i_clk), .i_rst(i_rst),
    .i_if_req(i_if_req), .i_if_addr(i_if_addr), .i_flush(i_flush),
    .o_if_valid(o_if_valid), .o_if_rdata(o_if_rdata), .o_stall_if(o_stall_if),
    .i_dm_read(i_dm_read), .i_dm_write(i_dm_write), .i_dm_addr(i_dm_addr),
    .i_dm_wdata(i_dm_wdata), .i_dm_mask(i_dm_mask),
    .o_dm_valid(o_dm_valid), .o_dm_rdata(o_dm_rdata), .o_stall_mem(o_stall_mem),
    .o_mem_req(o_mem_req), .o_mem_we(o_mem_we), .o_mem_addr(o_mem_addr),
    .o_mem_wdata(o_mem_wdata), .o_mem_mask(o_mem_mask),
    .i_mem_ready(i_mem_ready), .i_mem_rvalid(i_mem_rvalid), .i_mem_rdata(i_mem_rdata)
  );

  always #5 i_clk = ~i_clk;

  int vectors = 0;
  int miscompares = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_mem_req"},   o_mem_req,   0);
    chk({tag, "_mem_we"},    o_mem_we,    0);
    chk({tag, "_mem_addr"},  o_mem_addr,  0);
    chk({tag, "_mem_wdata"}, o_mem_wdata, 0);
    chk({tag, "_mem_mask"},  o_mem_mask,  0);
    chk({tag, "_if_valid"},  o_if_valid,  0);
    chk({tag, "_dm_valid"},  o_dm_valid,  0);
    chk({tag, "_stall_if"},  o_stall_if,  0);
    chk({tag, "_stall_mem"}, o_stall_mem, 0);
    chk({tag, "_if_rdata"},  o_if_rdata,  0);
    chk({tag, "_dm_rdata"},  o_dm_rdata,  0);
  endtask

  // Memory contents seen by the randomized phase.
  function automatic logic [31:0] fmem(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  // Transaction-level model state for the randomized phase.
  int          own;          // 0 none, 1 data, 2 fetch
  logic        accepted, drop, prev_req, take_if;
  int          rv_wait;
  logic        e_we;
  logic [31:0] e_addr, e_wdata, exp_rd;
  logic [3:0]  e_mask;
  logic        exp_dmv, exp_ifv;
  logic        p_dm_want, p_if_want, p_if_req, p_dm_we;
  logic [31:0] p_dm_addr, p_dm_wdata, p_if_addr;
  logic [3:0]  p_dm_mask;
  logic        dm_retire, if_retire;
  int          streak;

  initial begin
    // Reset state
    tick();
    chk_all_zero("rst");
    i_rst = 1'b1;
    tick();

    // Single load, minimum latency
    i_dm_read = 1'b1; i_dm_addr = 32'h100;
    #1; chk("ld_stall_n0", o_stall_mem, 1); chk("ld_req_n0", o_mem_req, 0);
    tick(); i_mem_ready = 1'b1;
    #1; chk("ld_req_n1", o_mem_req, 1); chk("ld_addr_n1", o_mem_addr, 32'h100);
    chk("ld_we_n1", o_mem_we, 0); chk("ld_mask_n1", o_mem_mask, 4'hF);
    chk("ld_stall_n1", o_stall_mem, 1);
    tick(); i_mem_ready = 1'b0; i_mem_rvalid = 1'b1; i_mem_rdata = 32'hDEAD_BEEF;
    #1; chk("ld_req_n2", o_mem_req, 0); chk("ld_valid_n2", o_dm_valid, 0);
    chk("ld_stall_n2", o_stall_mem, 1);
    tick(); i_mem_rvalid = 1'b0;
    #1; chk("ld_valid_n3", o_dm_valid, 1); chk("ld_rdata_n3", o_dm_rdata, 32'hDEAD_BEEF);
    chk("ld_stall_n3", o_stall_mem, 0);
    tick(); i_dm_read = 1'b0;
    #1; chk("ld_valid_n4", o_dm_valid, 0); chk("ld_req_n4", o_mem_req, 0);

    // Simultaneous fetch and store: store wins
    tick();
    i_if_req = 1'b1; i_if_addr = 32'h40;
    i_dm_write = 1'b1; i_dm_addr = 32'h200; i_dm_wdata = 32'h1234_5678; i_dm_mask = 4'hF;
    #1; chk("sim_stall_if_n0", o_stall_if, 1);
    tick(); i_mem_ready = 1'b1;
    #1; chk("sim_st_req", o_mem_req, 1); chk("sim_st_we", o_mem_we, 1);
    chk("sim_st_addr", o_mem_addr, 32'h200); chk("sim_st_wdata", o_mem_wdata, 32'h1234_5678);
    chk("sim_st_mask", o_mem_mask, 4'hF); chk("sim_stall_if_n1", o_stall_if, 1);
    tick(); i_mem_ready = 1'b0; i_mem_rvalid = 1'b1; i_mem_rdata = 32'h0;
    #1; chk("sim_stall_if_n2", o_stall_if, 1);
    tick(); i_mem_rvalid = 1'b0;
    #1; chk("sim_st_ack", o_dm_valid, 1); chk("sim_stall_mem_n3", o_stall_mem, 0);
    chk("sim_stall_if_n3", o_stall_if, 1); chk("sim_req_n3", o_mem_req, 0);
    tick(); i_dm_write = 1'b0; i_mem_ready = 1'b1;
    #1; chk("sim_if_req", o_mem_req, 1); chk("sim_if_addr", o_mem_addr, 32'h40);
    chk("sim_if_we", o_mem_we, 0); chk("sim_if_mask", o_mem_mask, 4'hF);
    chk("sim_stall_if_n4", o_stall_if, 1);
    tick(); i_mem_ready = 1'b0; i_mem_rvalid = 1'b1; i_mem_rdata = 32'hCAFE_0040;
    tick(); i_mem_rvalid = 1'b0;
    #1; chk("sim_if_valid", o_if_valid, 1); chk("sim_if_rdata", o_if_rdata, 32'hCAFE_0040);
    chk("sim_stall_if_n6", o_stall_if, 0);
    tick(); i_if_req = 1'b0;
    #1; chk("sim_if_valid_off", o_if_valid, 0);

    // Memory not ready for five cycles: request held stable
    tick();
    i_dm_write = 1'b1; i_dm_addr = 32'h300; i_dm_wdata = 32'hA5A5_5A5A; i_dm_mask = 4'h3;
    for (int k = 0; k < 5; k++) begin
      tick();
      #1; chk("hold_req", o_mem_req, 1); chk("hold_addr", o_mem_addr, 32'h300);
      chk("hold_wdata", o_mem_wdata, 32'hA5A5_5A5A); chk("hold_valid", o_dm_valid, 0);
    end
    chk("hold_mask", o_mem_mask, 4'h3);
    tick(); i_mem_ready = 1'b1;
    tick(); i_mem_ready = 1'b0; i_mem_rvalid = 1'b1; i_mem_rdata = 32'h0000_ACED;
    tick(); i_mem_rvalid = 1'b0;
    #1; chk("hold_ack", o_dm_valid, 1); chk("hold_ack_data", o_dm_rdata, 32'h0000_ACED);
    tick(); i_dm_write = 1'b0;

    // Flush during WAIT_IF, then a clean fetch
    tick();
    i_if_req = 1'b1; i_if_addr = 32'h80;
    tick(); i_mem_ready = 1'b1;
    #1; chk("fl_req", o_mem_req, 1); chk("fl_addr", o_mem_addr, 32'h80);
    tick(); i_mem_ready = 1'b0; i_flush = 1'b1; i_if_addr = 32'h90;
    #1; chk("fl_wait_req", o_mem_req, 0);
    tick(); i_flush = 1'b0; i_mem_rvalid = 1'b1; i_mem_rdata = 32'h1111_1111;
    tick(); i_mem_rvalid = 1'b0;
    #1; chk("fl_suppressed", o_if_valid, 0);
    tick(); i_mem_ready = 1'b1;
    #1; chk("fl2_req", o_mem_req, 1); chk("fl2_addr", o_mem_addr, 32'h90);
    tick(); i_mem_ready = 1'b0; i_mem_rvalid = 1'b1; i_mem_rdata = 32'h2222_2222;
    tick(); i_mem_rvalid = 1'b0;
    #1; chk("fl2_valid", o_if_valid, 1); chk("fl2_rdata", o_if_rdata, 32'h2222_2222);
    tick(); i_if_req = 1'b0;

    // Asynchronous reset during WAIT_DM
    tick();
    i_dm_read = 1'b1; i_dm_addr = 32'h400;
    tick(); i_mem_ready = 1'b1;
    tick(); i_mem_ready = 1'b0;
    #1; chk("ar_wait_req", o_mem_req, 0); chk("ar_wait_stall", o_stall_mem, 1);
    #1; i_rst = 1'b0;
    #1; chk_all_zero("ar");
    i_dm_read = 1'b0;
    tick(); tick();
    i_rst = 1'b1; i_mem_rvalid = 1'b1; i_mem_rdata = 32'hBAD0_BAD0;
    tick(); i_mem_rvalid = 1'b0;
    #1; chk("ar_late_dm", o_dm_valid, 0); chk("ar_late_if", o_if_valid, 0);
    chk("ar_late_req", o_mem_req, 0); chk("ar_late_rdata", o_dm_rdata, 0);

    // Randomized traffic against the transaction model
    own = 0; accepted = 0; drop = 0; prev_req = 0; rv_wait = 0; take_if = 0;
    e_we = 0; e_addr = '0; e_wdata = '0; e_mask = '0; exp_rd = '0;
    exp_dmv = 0; exp_ifv = 0; p_dm_want = 0; p_if_want = 0; p_if_req = 0; p_dm_we = 0;
    p_dm_addr = '0; p_dm_wdata = '0; p_if_addr = '0; p_dm_mask = '0;
    dm_retire = 0; if_retire = 0; streak = 0;
    for (int c = 0; c < 4000; c++) begin
      tick();
      chk("r_dm_valid", o_dm_valid, exp_dmv);
      chk("r_if_valid", o_if_valid, exp_ifv);
      if (exp_dmv) chk("r_dm_rdata", o_dm_rdata, exp_rd);
      if (exp_ifv) chk("r_if_rdata", o_if_rdata, exp_rd);
      exp_dmv = 0; exp_ifv = 0;

      if (o_mem_req && !prev_req) begin
        chk("r_spurious_grant", o_mem_req & ~(p_dm_want | p_if_want), 0);
`ifdef ARB_FAIRNESS_EN
        take_if = p_if_want && (!p_dm_want || streak == MAXS);
`else
        take_if = p_if_want && !p_dm_want;
`endif
        own = take_if ? 2 : 1;
`ifdef ARB_FAIRNESS_EN
        if (take_if) streak = 0;
        else if (p_if_req && streak < MAXS) streak++;
`endif
        e_we    = take_if ? 1'b0 : p_dm_we;
        e_addr  = take_if ? p_if_addr : p_dm_addr;
        e_wdata = p_dm_wdata;
        e_mask  = take_if ? 4'hF : p_dm_mask;
        accepted = 0; drop = 0;
      end
      if (o_mem_req) begin
        chk("r_mem_addr", o_mem_addr, e_addr);
        chk("r_mem_we", o_mem_we, e_we);
        chk("r_mem_mask", o_mem_mask, e_mask);
        if (e_we) chk("r_mem_wdata", o_mem_wdata, e_wdata);
      end

      if (o_dm_valid) dm_retire = 1;
      else if (dm_retire || (!i_dm_read && !i_dm_write && $urandom_range(3) == 0)) begin
        i_dm_read = 0; i_dm_write = 0;
        if (!dm_retire || $urandom_range(1) == 1) begin
          if ($urandom_range(1) == 1) i_dm_write = 1; else i_dm_read = 1;
          i_dm_addr = $urandom & 32'hFFFF_FFFC; i_dm_wdata = $urandom;
          i_dm_mask = 4'($urandom_range(15));
        end
        dm_retire = 0;
      end

      i_flush = 0;
      if (o_if_valid) if_retire = 1;
      else if (if_retire) begin
        if_retire = 0; i_if_req = ($urandom_range(3) != 0); i_if_addr = $urandom & 32'hFFFF_FFFC;
      end else if (!i_if_req && $urandom_range(3) == 0) begin
        i_if_req = 1; i_if_addr = $urandom & 32'hFFFF_FFFC;
      end else if (i_if_req && $urandom_range(9) == 0) begin
        i_flush = 1; i_if_addr = $urandom & 32'hFFFF_FFFC;
      end
      if (i_flush && own == 2) drop = 1;

      i_mem_ready = 0; i_mem_rvalid = 0; i_mem_rdata = $urandom;
      if (own != 0 && accepted) begin
        if (rv_wait == 0) begin
          i_mem_rvalid = 1; i_mem_rdata = fmem(e_addr); exp_rd = fmem(e_addr);
          exp_dmv = (own == 1); exp_ifv = (own == 2) && !drop;
          own = 0; accepted = 0;
        end else rv_wait--;
      end else if (o_mem_req) i_mem_ready = ($urandom_range(1) == 1);

      #1;
      chk("r_stall_mem", o_stall_mem, (i_dm_read | i_dm_write) & ~o_dm_valid);
      chk("r_stall_if", o_stall_if,
          (i_if_req & ~o_if_valid) | ((i_dm_read | i_dm_write) & ~o_dm_valid));

      if (o_mem_req && i_mem_ready) begin accepted = 1; rv_wait = $urandom_range(2); end
      p_dm_want  = (i_dm_read | i_dm_write) & ~o_dm_valid;
      p_if_want  = i_if_req & ~i_flush & ~o_if_valid;
      p_if_req   = i_if_req;
      p_dm_we    = i_dm_write;
      p_dm_addr  = i_dm_addr;
      p_dm_wdata = i_dm_wdata;
      p_dm_mask  = i_dm_write ? i_dm_mask : 4'hF;
      p_if_addr  = i_if_addr;
      if (!i_if_req) streak = 0;
      prev_req = o_mem_req;
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
